// File: rtl/rca_seq_if.sv
// rca_seq_if: operand/result bundle for rca_seq
//   start, A, B, Cin : launch request and operands (driven by master)
//   sub              : subtract select, present only with RCA_SEQ_SUB_EN
//   busy, done       : slice processing flag and one-cycle completion pulse
//   Sum, Cout        : result and final carry-out registers
interface rca_seq_if #(
   parameter int N = 32
);
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         Cin;
`ifdef RCA_SEQ_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [N-1:0] Sum;
   logic         Cout;

   modport master (
      output start, A, B, Cin,
`ifdef RCA_SEQ_SUB_EN
      output sub,
`endif
      input  busy, done, Sum, Cout
   );

   modport slave (
      input  start, A, B, Cin,
`ifdef RCA_SEQ_SUB_EN
      input  sub,
`endif
      output busy, done, Sum, Cout
   );
endinterface

// File: rtl/rca_seq.sv
// rca_seq: multi-cycle ripple-carry adder, one W-bit slice per clock, LSB slice first
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rca_seq_if slave (start/A/B/Cin in, busy/done/Sum/Cout out)
//   RCA_SEQ_SUB_EN : when defined, bus.sub selects A-B (B inverted, carry-in forced to 1)
module rca_seq #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   rca_seq_if.slave bus
);
   localparam int K  = N / W;
   localparam int CW = (K > 1) ? $clog2(K) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t        state, state_nx;
   logic [N-1:0]  a_q, b_q, sum_q, b_in;
   logic [CW-1:0] cnt;
   logic          carry, cout_q, c_in, accept, last;
   logic [W:0]    slice;
`ifdef RCA_SEQ_SUB_EN
   assign b_in = bus.sub ? ~bus.B : bus.B;
   assign c_in = bus.sub | bus.Cin;
`else
   assign b_in = bus.B;
   assign c_in = bus.Cin;
`endif
   // start is only honoured outside RUN so operands stay frozen mid-operation
   assign accept = bus.start && state != RUN;
   assign last   = cnt == CW'(K - 1);
   assign slice  = {1'b0, a_q[cnt*W +: W]} + {1'b0, b_q[cnt*W +: W]} + {{W{1'b0}}, carry};
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept ? RUN : IDLE;
         RUN:     state_nx = last ? DONE : RUN;
         DONE:    state_nx = accept ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            a_q   <= bus.A;
            b_q   <= b_in;
            carry <= c_in;
            cnt   <= '0;
         end else if (state == RUN) begin
            sum_q[cnt*W +: W] <= slice[W-1:0];
            carry             <= slice[W];
            // counter parks on the last slice instead of wrapping
            if (last) cout_q <= slice[W];
            else cnt <= cnt + CW'(1);
         end
      end
   end
   assign bus.busy = state == RUN;
   assign bus.done = state == DONE;
   assign bus.Sum  = sum_q;
   assign bus.Cout = cout_q;
endmodule

// File: tb/tb_rca_seq.sv
// tb_rca_seq: vector-table, directed and random checks of rca_seq (32/8 and 16/16 builds)
module tb_rca_seq;
   logic clk = 1'b0;
   logic rst_n;
   int   vecs = 0;
   int   miscompares = 0;

   rca_seq_if #(.N(32)) b32 ();
   rca_seq_if #(.N(16)) b16 ();

   rca_seq #(.N(32), .W(8))  u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
   rca_seq #(.N(16), .W(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
   } vec_t;
   vec_t tbl[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // called at a negedge; the following posedge is the accepting edge
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic cin);
      b32.A = a;
      b32.B = b;
      b32.Cin = cin;
      b32.start = 1'b1;
      @(negedge clk);
      b32.start = 1'b0;
      b32.A = $urandom;
      b32.B = $urandom;
      b32.Cin = 1'($urandom);
   endtask

   // entered at the first negedge after the accepting edge; cyc = edges until done
   task automatic wait_done(output int cyc, output int bz);
      cyc = 0;
      bz = 0;
      while (b32.done !== 1'b1 && cyc < 20) begin
         if (b32.busy === 1'b1) bz++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic check_op(input string name, input logic [31:0] es, input logic ec);
      int cyc, bz;
      wait_done(cyc, bz);
      chk({name, " latency"}, 64'(cyc), 64'd4);
      chk({name, " busy"}, 64'(bz), 64'd4);
      chk({name, " sum"}, 64'(b32.Sum), 64'(es));
      chk({name, " cout"}, 64'(b32.Cout), 64'(ec));
   endtask

   task automatic check_tail(input string name, input logic [31:0] es, input logic ec);
      @(negedge clk);
      chk({name, " done pulse"}, 64'(b32.done), 64'd0);
      chk({name, " hold"}, {31'd0, b32.Cout, b32.Sum}, {31'd0, ec, es});
   endtask

   initial begin
      int cyc, bz, pulses;
      logic [32:0] ref_r;
      logic [31:0] ra, rb;
      logic rc;
      tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
      tbl[1] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
      tbl[2] = '{32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0};
      tbl[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
      tbl[4] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
      tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
      tbl[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
      rst_n = 1'b0;
      b32.start = 1'b0; b32.A = '0; b32.B = '0; b32.Cin = 1'b0;
      b16.start = 1'b0; b16.A = '0; b16.B = '0; b16.Cin = 1'b0;
`ifdef RCA_SEQ_SUB_EN
      b32.sub = 1'b0;
      b16.sub = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      chk("reset outs32", {b32.busy, b32.done, b32.Cout, b32.Sum}, 64'd0);
      chk("reset outs16", {b16.busy, b16.done, b16.Cout, b16.Sum}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         launch(tbl[i].a, tbl[i].b, tbl[i].cin);
         check_op($sformatf("tbl%0d", i), tbl[i].sum, tbl[i].cout);
         check_tail($sformatf("tbl%0d", i), tbl[i].sum, tbl[i].cout);
      end

      // start held through RUN while operands change: must be ignored
      b32.A = 32'h12345678; b32.B = 32'h11111111; b32.Cin = 1'b1; b32.start = 1'b1;
      @(negedge clk);
      b32.A = 32'hDEADBEEF; b32.B = 32'hCAFEF00D; b32.Cin = 1'b0;
      @(negedge clk);
      b32.A = 32'h0F0F0F0F;
      @(negedge clk);
      b32.start = 1'b0;
      wait_done(cyc, bz);
      chk("hold latency", 64'(cyc), 64'd2);
      chk("hold sum", 64'(b32.Sum), 64'h2345678A);
      chk("hold cout", 64'(b32.Cout), 64'd0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (b32.done === 1'b1) pulses++;
      end
      chk("hold extra done", 64'(pulses), 64'd0);

      // back-to-back: new start accepted in the DONE cycle
      launch(32'h00000001, 32'h00000002, 1'b0);
      check_op("b2b first", 32'h00000003, 1'b0);
      launch(32'h00000003, 32'h00000004, 1'b0);
      check_op("b2b second", 32'h00000007, 1'b0);
      check_tail("b2b", 32'h00000007, 1'b0);

      // reset on the second RUN cycle
      launch(32'hFFFF0000, 32'h0000FFFF, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrun reset outs", {b32.busy, b32.done, b32.Cout, b32.Sum}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (b32.done === 1'b1 || b32.busy === 1'b1) pulses++;
      end
      chk("post reset idle", 64'(pulses), 64'd0);
      launch(32'h0000FFFF, 32'h00000001, 1'b0);
      check_op("post reset op", 32'h00010000, 1'b0);
      check_tail("post reset op", 32'h00010000, 1'b0);

      // single-slice build: N=W=16
      b16.A = 16'h8000; b16.B = 16'h8000; b16.Cin = 1'b1; b16.start = 1'b1;
      @(negedge clk);
      b16.start = 1'b0; b16.A = 16'h1234; b16.B = 16'h4321;
      chk("k1 busy", {62'd0, b16.busy, b16.done}, 64'd2);
      @(negedge clk);
      chk("k1 done", 64'(b16.done), 64'd1);
      chk("k1 result", {47'd0, b16.Cout, b16.Sum}, {47'd0, 1'b1, 16'h0001});
      @(negedge clk);
      chk("k1 pulse", 64'(b16.done), 64'd0);

      // random operands against plain arithmetic
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = (i % 4 == 0) ? ~ra : $urandom;
         rc = 1'($urandom);
         ref_r = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
         launch(ra, rb, rc);
         check_op($sformatf("rand%0d", i), ref_r[31:0], ref_r[32]);
         if (i % 3 == 0) check_tail($sformatf("rand%0d", i), ref_r[31:0], ref_r[32]);
      end

`ifdef RCA_SEQ_SUB_EN
      @(negedge clk);
      b32.sub = 1'b1;
      launch(32'h00000005, 32'h00000007, 1'b0);
      check_op("sub 5-7", 32'hFFFFFFFE, 1'b0);
      @(negedge clk);
      launch(32'h00000007, 32'h00000005, 1'b0);
      check_op("sub 7-5", 32'h00000002, 1'b1);
      b32.sub = 1'b0;
`endif

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end
endmodule
